game_physics: RTL and testbench

//  Parametrised per-frame game engine: paddle, one ball, walls, lives, serve/launch.

---
 rtl/game_physics_pkg.sv | 32 +++
 rtl/game_physics_btn_sync.sv | 21 ++
 rtl/game_physics.sv | 203 ++++++++++++++++++++
 tb/tb_game_physics.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_physics_pkg.sv
// Shared definitions for the game_physics engine: default geometry, state enums
// and the signed coordinate type used for all intermediate position math.
package game_physics_pkg;

    localparam int PIXEL_W = 10;
    localparam int COORD_W = 12;

    localparam int DEF_SCREEN_W            = 800;
    localparam int DEF_SCREEN_H            = 600;
    localparam int DEF_PADDLE_LENGTH_PIXEL = 60;
    localparam int DEF_PADDLE_Y            = 580;
    localparam int DEF_PADDLE_SPEED        = 4;
    localparam int DEF_BALL_SIZE           = 8;
    localparam int DEF_BALL_SPEED          = 2;
    localparam int DEF_START_LIVES         = 3;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        GS_SERVE,
        GS_PLAY,
        GS_GAME_OVER
    } game_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_PADDLE,
        SEQ_BALL,
        SEQ_COMMIT
    } seq_state_t;

endpackage

// File: rtl/game_physics_btn_sync.sv
// Two-flop synchroniser for one asynchronous push-button input.
module game_physics_btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);
    logic meta;

    // NOTE: flops use non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/game_physics.sv
// Per-frame paddle/ball engine: steps paddle then ball after each frame-done pulse
// and publishes positions, lives and audio events together in the commit cycle.
module game_physics
    import game_physics_pkg::*;
#(
    parameter int SCREEN_W            = DEF_SCREEN_W,
    parameter int SCREEN_H            = DEF_SCREEN_H,
    parameter int PADDLE_LENGTH_PIXEL = DEF_PADDLE_LENGTH_PIXEL,
    parameter int PADDLE_Y            = DEF_PADDLE_Y,
    parameter int PADDLE_SPEED        = DEF_PADDLE_SPEED,
    parameter int BALL_SIZE           = DEF_BALL_SIZE,
    parameter int BALL_SPEED          = DEF_BALL_SPEED,
    parameter int START_LIVES         = DEF_START_LIVES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_update,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_launch,
    output logic [PIXEL_W-1:0] paddle_x_pixel,
    output logic [PIXEL_W-1:0] ball_x_pixel,
    output logic [PIXEL_W-1:0] ball_y_pixel,
    output logic               ball_active,
    output logic [1:0]         lives,
    output logic               update_done,
    output logic               event_bounce,
    output logic               event_lost
);
    localparam coord_t ZERO           = '0;
    localparam coord_t PLEN           = coord_t'(PADDLE_LENGTH_PIXEL);
    localparam coord_t BSIZE          = coord_t'(BALL_SIZE);
    localparam coord_t P_SPEED        = coord_t'(PADDLE_SPEED);
    localparam coord_t B_SPEED        = coord_t'(BALL_SPEED);
    localparam coord_t PADDLE_X_MAX   = coord_t'(SCREEN_W - PADDLE_LENGTH_PIXEL);
    localparam coord_t PADDLE_X_RESET = coord_t'((SCREEN_W - PADDLE_LENGTH_PIXEL) / 2);
    localparam coord_t BALL_X_MAX     = coord_t'(SCREEN_W - BALL_SIZE);
    localparam coord_t PARK_OFFSET    = coord_t'((PADDLE_LENGTH_PIXEL - BALL_SIZE) / 2);
    localparam coord_t PARK_Y         = coord_t'(PADDLE_Y - BALL_SIZE);
    localparam coord_t PARK_X_RESET   = PADDLE_X_RESET + PARK_OFFSET;
    localparam coord_t PADDLE_TOP     = coord_t'(PADDLE_Y);
    localparam coord_t BOTTOM         = coord_t'(SCREEN_H);
    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

    logic left_s, right_s, launch_s;

    game_physics_btn_sync u_sync_left   (.clk(clk), .rst_n(rst_n), .async_in(btn_left),   .sync_out(left_s));
    game_physics_btn_sync u_sync_right  (.clk(clk), .rst_n(rst_n), .async_in(btn_right),  .sync_out(right_s));
    game_physics_btn_sync u_sync_launch (.clk(clk), .rst_n(rst_n), .async_in(btn_launch), .sync_out(launch_s));

    seq_state_t  seq_q, seq_d;
    coord_t      pad_x_q, ball_x_q, ball_y_q, vx_q, vy_q;
    game_state_t game_q;
    logic [1:0]  lives_q;
    logic        bounce_q, lost_q;

    coord_t      pad_x_d, nx, ny, bx_n, by_n, vx_n, vy_n;
    game_state_t game_n;
    logic [1:0]  lives_n;
    logic        bounce_n, lost_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seq_q <= SEQ_IDLE;
        else        seq_q <= seq_d;
    end

    // A frame pulse arriving while a sequence is in flight is dropped.
    always_comb begin
        seq_d = seq_q;
        unique case (seq_q)
            SEQ_IDLE:   if (start_update) seq_d = SEQ_PADDLE;
            SEQ_PADDLE: seq_d = SEQ_BALL;
            SEQ_BALL:   seq_d = SEQ_COMMIT;
            SEQ_COMMIT: seq_d = SEQ_IDLE;
        endcase
    end

    always_comb begin
        update_done  = (seq_q == SEQ_COMMIT);
        event_bounce = (seq_q == SEQ_COMMIT) && bounce_q;
        event_lost   = (seq_q == SEQ_COMMIT) && lost_q;
    end

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        pad_x_d = pad_x_q;
        if (left_s && !right_s)
            pad_x_d = (pad_x_q >= P_SPEED) ? pad_x_q - P_SPEED : ZERO;
        else if (right_s && !left_s)
            pad_x_d = (pad_x_q + P_SPEED > PADDLE_X_MAX) ? PADDLE_X_MAX : pad_x_q + P_SPEED;
    end

    // Ball step runs one cycle after the paddle step, so pad_x_q is already this frame's paddle.
    always_comb begin
        nx       = ball_x_q + vx_q;
        ny       = ball_y_q + vy_q;
        bx_n     = ball_x_q;
        by_n     = ball_y_q;
        vx_n     = vx_q;
        vy_n     = vy_q;
        game_n   = game_q;
        lives_n  = lives_q;
        bounce_n = 1'b0;
        lost_n   = 1'b0;
        case (game_q)
            GS_SERVE: begin
                bx_n = pad_x_q + PARK_OFFSET;
                by_n = PARK_Y;
                if (launch_s) begin
                    vx_n   = B_SPEED;
                    vy_n   = -B_SPEED;
                    game_n = GS_PLAY;
                end
            end
            GS_PLAY: begin
                bx_n = nx;
                by_n = ny;
                if (nx < ZERO) begin
                    bx_n     = ZERO;
                    vx_n     = -vx_q;
                    bounce_n = 1'b1;
                end else if (nx > BALL_X_MAX) begin
                    bx_n     = BALL_X_MAX;
                    vx_n     = -vx_q;
                    bounce_n = 1'b1;
                end
                if (ny < ZERO) begin
                    by_n     = ZERO;
                    vy_n     = -vy_q;
                    bounce_n = 1'b1;
                end else if (vy_q > ZERO && ny + BSIZE >= PADDLE_TOP && ny < PADDLE_TOP &&
                             bx_n + BSIZE > pad_x_q && bx_n < pad_x_q + PLEN) begin
                    by_n     = PARK_Y;
                    vy_n     = -vy_q;
                    bounce_n = 1'b1;
                end else if (ny >= BOTTOM) begin
                    lost_n  = 1'b1;
                    lives_n = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        game_n = GS_GAME_OVER;
                    end else begin
                        game_n = GS_SERVE;
                        bx_n   = pad_x_q + PARK_OFFSET;
                        by_n   = PARK_Y;
                    end
                end
            end
            GS_GAME_OVER: begin
                if (launch_s) begin
                    lives_n = LIVES_INIT;
                    game_n  = GS_SERVE;
                    bx_n    = pad_x_q + PARK_OFFSET;
                    by_n    = PARK_Y;
                end
            end
            default: game_n = GS_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_x_q  <= PADDLE_X_RESET;
            ball_x_q <= PARK_X_RESET;
            ball_y_q <= PARK_Y;
            vx_q     <= ZERO;
            vy_q     <= ZERO;
            game_q   <= GS_SERVE;
            lives_q  <= LIVES_INIT;
            bounce_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            if (seq_q == SEQ_PADDLE) pad_x_q <= pad_x_d;
            if (seq_q == SEQ_BALL) begin
                ball_x_q <= bx_n;
                ball_y_q <= by_n;
                vx_q     <= vx_n;
                vy_q     <= vy_n;
                game_q   <= game_n;
                lives_q  <= lives_n;
                bounce_q <= bounce_n;
                lost_q   <= lost_n;
            end
        end
    end

    // Renderer-facing copies change only on the edge entering COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddle_x_pixel <= PADDLE_X_RESET[PIXEL_W-1:0];
            ball_x_pixel   <= PARK_X_RESET[PIXEL_W-1:0];
            ball_y_pixel   <= PARK_Y[PIXEL_W-1:0];
            ball_active    <= 1'b1;
            lives          <= LIVES_INIT;
        end else if (seq_q == SEQ_BALL) begin
            paddle_x_pixel <= pad_x_q[PIXEL_W-1:0];
            ball_x_pixel   <= bx_n[PIXEL_W-1:0];
            ball_y_pixel   <= by_n[PIXEL_W-1:0];
            ball_active    <= (game_n != GS_GAME_OVER);
            lives          <= lives_n;
        end
    end

endmodule

// File: tb/tb_game_physics.sv
// Scoreboard bench for game_physics: the driver pushes the expected frame result,
// a negedge monitor pops and compares whenever update_done is seen.
module tb_game_physics;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_update = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_launch = 1'b0;
    logic [9:0] paddle_x_pixel, ball_x_pixel, ball_y_pixel;
    logic       ball_active;
    logic [1:0] lives;
    logic       update_done, event_bounce, event_lost;

    game_physics dut (
        .clk(clk), .rst_n(rst_n), .start_update(start_update),
        .btn_left(btn_left), .btn_right(btn_right), .btn_launch(btn_launch),
        .paddle_x_pixel(paddle_x_pixel), .ball_x_pixel(ball_x_pixel), .ball_y_pixel(ball_y_pixel),
        .ball_active(ball_active), .lives(lives), .update_done(update_done),
        .event_bounce(event_bounce), .event_lost(event_lost)
    );

    always #10 clk = ~clk;

    typedef struct {
        int cyc;
        int px, bx, by, active, lives, bounce, lost;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0, n_fail = 0;
    int   cyc = 0, done_cnt = 0, bounce_pulses = 0, lost_pulses = 0;
    int   spurious = 0, unexpected = 0;

    // Reference model state (default geometry: 800x600, paddle 60 @ y580, ball 8).
    int m_px, m_bx, m_by, m_vx, m_vy, m_game, m_lives;
    bit m_lost_flag;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_px = 370; m_bx = 396; m_by = 572; m_vx = 0; m_vy = 0; m_game = 0; m_lives = 3;
    endtask

    task automatic model_step(input bit l, input bit r, input bit launch, output exp_t e);
        int x, y;
        bit hx, hy;
        e.bounce = 0;
        e.lost   = 0;
        if (l && !r)      m_px = (m_px - 4 < 0) ? 0 : m_px - 4;
        else if (r && !l) m_px = (m_px + 4 > 740) ? 740 : m_px + 4;
        if (m_game == 0) begin
            m_bx = m_px + 26;
            m_by = 572;
            if (launch) begin m_vx = 2; m_vy = -2; m_game = 1; end
        end else if (m_game == 1) begin
            x = m_bx + m_vx; y = m_by + m_vy; hx = 0; hy = 0;
            if (x < 0) begin x = 0; hx = 1; end
            else if (x > 792) begin x = 792; hx = 1; end
            if (y < 0) begin y = 0; hy = 1; end
            else if (m_vy > 0 && y >= 572 && y < 580 && x > m_px - 8 && x < m_px + 60) begin
                y = 572; hy = 1;
            end
            if (hx) m_vx = -m_vx;
            if (hy) m_vy = -m_vy;
            e.bounce = int'(hx | hy);
            m_bx = x; m_by = y;
            if (y >= 600) begin
                e.lost = 1;
                m_lives = m_lives - 1;
                if (m_lives == 0) m_game = 2;
                else begin m_game = 0; m_bx = m_px + 26; m_by = 572; end
            end
        end else if (launch) begin
            m_lives = 3; m_game = 0; m_bx = m_px + 26; m_by = 572;
        end
        e.px = m_px; e.bx = m_bx; e.by = m_by;
        e.active = (m_game != 2) ? 1 : 0;
        e.lives = m_lives;
        m_lost_flag = (e.lost != 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (event_bounce) bounce_pulses++;
            if (event_lost) lost_pulses++;
            if ((event_bounce || event_lost) && !update_done) spurious++;
            if (update_done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    unexpected++;
                end else begin
                    mon_e = sb.pop_front();
                    check("latency",  cyc - mon_e.cyc, 3);
                    check("paddle_x", int'(paddle_x_pixel), mon_e.px);
                    check("ball_x",   int'(ball_x_pixel), mon_e.bx);
                    check("ball_y",   int'(ball_y_pixel), mon_e.by);
                    check("active",   int'(ball_active), mon_e.active);
                    check("lives",    int'(lives), mon_e.lives);
                    check("bounce",   int'(event_bounce), mon_e.bounce);
                    check("lost",     int'(event_lost), mon_e.lost);
                end
            end
        end
    end

    task automatic frame(input bit l, input bit r, input bit launch, input bit repulse);
        exp_t e;
        int   d0;
        btn_left = l; btn_right = r; btn_launch = launch;
        repeat (3) @(posedge clk);
        #1;
        model_step(l, r, launch, e);
        e.cyc = cyc;
        sb.push_back(e);
        d0 = done_cnt;
        start_update = 1'b1;
        @(posedge clk); #1;
        start_update = 1'b0;
        if (repulse) begin
            start_update = 1'b1;
            @(posedge clk); #1;
            start_update = 1'b0;
        end
        for (int i = 0; i < 8 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) check("update_timeout", done_cnt - d0, 1);
        #1;
    endtask

    task automatic run_frames(input int n, input bit l, input bit r);
        m_lost_flag = 0;
        for (int i = 0; i < n; i++) begin
            frame(l, r, 1'b0, 1'b0);
            if (m_lost_flag) break;
        end
    endtask

    task automatic check_ball(input string name, input int x, input int y);
        check({name, "_x"}, int'(ball_x_pixel), x);
        check({name, "_y"}, int'(ball_y_pixel), y);
    endtask

    task automatic check_reset_state();
        check("rst_paddle_x", int'(paddle_x_pixel), 370);
        check_ball("rst_ball", 396, 572);
        check("rst_lives", int'(lives), 3);
        check("rst_active", int'(ball_active), 1);
        check("rst_done", int'(update_done), 0);
        check("rst_events", int'({event_bounce, event_lost}), 0);
    endtask

    initial begin
        #1_800_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_state();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 check_reset_state();

        // Second frame pulse during PADDLE step is ignored: one commit, one paddle step.
        frame(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        check("repulse_paddle_x", int'(paddle_x_pixel), 374);

        run_frames(45, 1'b1, 1'b0);
        check("left_paddle_x", int'(paddle_x_pixel), 194);

        // Launch from px=194 lines the ball up for an exact (792,0) corner.
        frame(1'b0, 1'b0, 1'b1, 1'b0);
        check_ball("launch_park", 220, 572);
        run_frames(1, 1'b0, 1'b0);
        check_ball("first_move", 222, 570);
        run_frames(285, 1'b0, 1'b0);
        check_ball("at_limits", 792, 0);
        check("no_bounce_before_corner", bounce_pulses, 0);
        run_frames(1, 1'b0, 1'b0);
        check_ball("corner", 792, 0);
        check("corner_single_pulse", bounce_pulses, 1);
        run_frames(1, 1'b0, 1'b0);
        check_ball("after_corner", 790, 2);

        run_frames(137, 1'b0, 1'b1);
        check("right_sat_paddle_x", int'(paddle_x_pixel), 740);
        run_frames(5, 1'b1, 1'b1);
        check("both_hold_paddle_x", int'(paddle_x_pixel), 740);
        run_frames(3000, 1'b0, 1'b0);
        check("life1_lives", int'(lives), 2);
        check("life1_lost_pulses", lost_pulses, 1);
        check_ball("life1_park", 766, 572);

        // Second life: paddle moved under the landing point for a paddle bounce.
        frame(1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(299, 1'b0, 1'b0);
        run_frames(104, 1'b1, 1'b0);
        check("catch_paddle_x", int'(paddle_x_pixel), 324);
        run_frames(3000, 1'b0, 1'b0);
        check("life2_lives", int'(lives), 1);
        check("life2_lost_pulses", lost_pulses, 2);

        frame(1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(3000, 1'b0, 1'b0);
        check("over_lives", int'(lives), 0);
        check("over_active", int'(ball_active), 0);
        check("over_lost_pulses", lost_pulses, 3);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("over_hold_active", int'(ball_active), 0);
        frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("restart_lives", int'(lives), 3);
        check("restart_active", int'(ball_active), 1);
        check_ball("restart_park", 350, 572);

        // Reset asserted during the BALL step: nothing commits.
        d0 = done_cnt;
        @(posedge clk); #1 start_update = 1'b1;
        @(posedge clk); #1 start_update = 1'b0;
        @(posedge clk); #5 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 check("no_commit_after_reset", done_cnt - d0, 0);
        model_reset();
        check_reset_state();

        frame(1'b0, 1'b0, 1'b1, 1'b0);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        check_ball("launch_two_updates", 398, 570);

        repeat (10) @(posedge clk);
        check("spurious_events", spurious, 0);
        check("unexpected_updates", unexpected, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
